// File: rtl/dac_intf.sv
// DAC-side transmit interface: buffers IQ words in a small FIFO, repeats each word for two
// DAC strobes (x2 sample-and-hold), applies a per-lane arithmetic attenuation and sequences
// the IDLE -> PREFILL -> RUN -> DRAIN flow with sticky underflow reporting.
module dac_intf #(
   parameter int unsigned IQ_DATA_WIDTH   = 16,
   parameter int unsigned FIFO_DEPTH_LOG2 = 4,
   parameter int unsigned PREFILL_THRESH  = 4
) (
   input  logic                           dac_clk,
   input  logic                           dac_rst,
   input  logic [4*IQ_DATA_WIDTH-1:0]     data_from_acc,
   input  logic                           data_from_acc_valid,
   output logic                           fulln_to_acc,
   input  logic                           tx_en,
   input  logic [2:0]                     tx_atten,
   input  logic                           dac_valid,
   output logic [4*IQ_DATA_WIDTH-1:0]     dac_data,
   output logic                           underflow,
   input  logic                           underflow_clr,
   output logic [FIFO_DEPTH_LOG2:0]       fifo_count,
   output logic                           tx_busy
);

   localparam int unsigned IQW   = IQ_DATA_WIDTH;
   localparam int unsigned DW    = 4 * IQW;
   localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
   localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {StIdle, StPrefill, StRun, StDrain} state_e;

   logic [DW-1:0]              r_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
   logic [CW-1:0]              r_count;
   state_e                     r_state;
   logic                       r_phase;
   logic [DW-1:0]              r_dac_data;
   logic                       r_underflow;

   logic          w_full;
   logic          w_empty;
   logic          w_wr;
   logic          w_active;
   logic          w_pop;
   logic          w_uf_set;
   logic [DW-1:0] w_head;
   logic [DW-1:0] w_atten;
   logic [2:0]    w_shift;

   assign w_full       = (r_count == CW'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_wr         = data_from_acc_valid & ~w_full;
   assign w_active     = (r_state == StRun) || (r_state == StDrain);
   // Pops happen only on the phase-0 strobe; the phase-1 strobe re-uses the held word
   assign w_pop        = w_active & dac_valid & ~r_phase & ~w_empty;
   assign w_uf_set     = (r_state == StRun) & dac_valid & ~r_phase & w_empty;
   assign w_head       = r_mem[r_rd_ptr];

   assign fulln_to_acc = ~w_full;
   assign fifo_count   = r_count;
   assign dac_data     = r_dac_data;
   assign underflow    = r_underflow;
   assign tx_busy      = (r_state != StIdle);

   // Per-lane sign-preserving attenuation; out-of-range shift codes pass data through
   always_comb begin
      w_atten = '0;
      w_shift = (tx_atten <= 3'd4) ? tx_atten : 3'd0;
      for (int l = 0; l < 4; l++) begin
         w_atten[l*IQW +: IQW] = IQW'($signed(w_head[l*IQW +: IQW]) >>> w_shift);
      end
   end

   // FIFO storage; no reset needed since occupancy gates every read
   always_ff @(posedge dac_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= data_from_acc;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge dac_clk) begin
      if (dac_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sequencing FSM with registered DAC data, interpolation phase and underflow flag
   always_ff @(posedge dac_clk) begin
      if (dac_rst) begin
         r_state     <= StIdle;
         r_phase     <= 1'b0;
         r_dac_data  <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (w_uf_set) begin
            r_underflow <= 1'b1;
         end else if (underflow_clr) begin
            r_underflow <= 1'b0;
         end

         case (r_state)
            StIdle: begin
               r_phase    <= 1'b0;
               r_dac_data <= '0;
               if (tx_en) r_state <= StPrefill;
            end
            StPrefill: begin
               r_phase    <= 1'b0;
               r_dac_data <= '0;
               if (!tx_en) begin
                  r_state <= StIdle;
               end else if (r_count >= CW'(PREFILL_THRESH)) begin
                  r_state <= StRun;
               end
            end
            StRun, StDrain: begin
               if (dac_valid) begin
                  r_phase <= ~r_phase;
                  if (!r_phase) begin
                     r_dac_data <= w_empty ? '0 : w_atten;
                  end
               end
               // An empty FIFO at a pop point ends the drain; otherwise follow tx_en
               if ((r_state == StDrain) && dac_valid && !r_phase && w_empty) begin
                  r_state <= StIdle;
               end else if ((r_state == StRun) && !tx_en) begin
                  r_state <= StDrain;
               end else if ((r_state == StDrain) && tx_en) begin
                  r_state <= StRun;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_intf.sv
// Directed bench for dac_intf: reset, FIFO full, run/interpolation, underflow, attenuation,
// drain and mid-run reset, each in its own task with inline comparisons.
module tb_dac_intf;

   localparam int unsigned IQW = 16;
   localparam int unsigned DW  = 4 * IQW;

   logic          clk;
   logic          rst;
   logic [DW-1:0] din;
   logic          din_valid;
   logic          fulln;
   logic          tx_en;
   logic [2:0]    tx_atten;
   logic          dac_valid;
   logic [DW-1:0] dac_data;
   logic          underflow;
   logic          underflow_clr;
   logic [4:0]    fifo_count;
   logic          tx_busy;

   int n_checks = 0;
   int n_fail   = 0;

   dac_intf #(
      .IQ_DATA_WIDTH  (16),
      .FIFO_DEPTH_LOG2(4),
      .PREFILL_THRESH (4)
   ) dut (
      .dac_clk            (clk),
      .dac_rst            (rst),
      .data_from_acc      (din),
      .data_from_acc_valid(din_valid),
      .fulln_to_acc       (fulln),
      .tx_en              (tx_en),
      .tx_atten           (tx_atten),
      .dac_valid          (dac_valid),
      .dac_data           (dac_data),
      .underflow          (underflow),
      .underflow_clr      (underflow_clr),
      .fifo_count         (fifo_count),
      .tx_busy            (tx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] w);
      din       = w;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic strobe();
      dac_valid = 1'b1;
      tick();
      dac_valid = 1'b0;
   endtask

   function automatic logic [DW-1:0] run_word(input int i);
      return 64'h0004_0003_0002_0001 + 64'(i) * 64'h0010_0010_0010_0010;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         dac_valid = ~dac_valid;
         tick();
      end
      dac_valid = 1'b0;
      rst = 1'b0;
      n_checks++;
      if (dac_data !== '0) begin
         n_fail++; $display("FAIL reset_dac_data: got %h want 0", dac_data);
      end
      n_checks++;
      if (fulln !== 1'b1) begin
         n_fail++; $display("FAIL reset_fulln: got %b want 1", fulln);
      end
      n_checks++;
      if (fifo_count !== 5'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count);
      end
      n_checks++;
      if (tx_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy);
      end
      n_checks++;
      if (underflow !== 1'b0) begin
         n_fail++; $display("FAIL reset_underflow: got %b want 0", underflow);
      end
   endtask

   task automatic test_fifo_full();
      for (int i = 1; i <= 16; i++) write_word(64'(i));
      n_checks++;
      if (fifo_count !== 5'd16) begin
         n_fail++; $display("FAIL full_count: got %0d want 16", fifo_count);
      end
      n_checks++;
      if (fulln !== 1'b0) begin
         n_fail++; $display("FAIL full_fulln: got %b want 0", fulln);
      end
      write_word(64'd17);
      n_checks++;
      if (fifo_count !== 5'd16) begin
         n_fail++; $display("FAIL full_overwrite_count: got %0d want 16", fifo_count);
      end
      n_checks++;
      if (tx_busy !== 1'b0) begin
         n_fail++; $display("FAIL full_idle_busy: got %b want 0", tx_busy);
      end
      do_reset();
      n_checks++;
      if (fifo_count !== 5'd0 || fulln !== 1'b1) begin
         n_fail++; $display("FAIL full_reset_clear: got count %0d fulln %b want 0 1", fifo_count, fulln);
      end
   endtask

   task automatic test_run();
      for (int i = 0; i < 4; i++) write_word(run_word(i));
      tx_en = 1'b1;
      tick();
      n_checks++;
      if (tx_busy !== 1'b1) begin
         n_fail++; $display("FAIL run_busy: got %b want 1", tx_busy);
      end
      tick();
      n_checks++;
      if (dac_data !== '0 || fifo_count !== 5'd4) begin
         n_fail++; $display("FAIL run_prepop: got data %h count %0d want 0 4", dac_data, fifo_count);
      end
      for (int i = 0; i < 4; i++) begin
         strobe();
         n_checks++;
         if (dac_data !== run_word(i)) begin
            n_fail++; $display("FAIL run_ph0_word%0d: got %h want %h", i, dac_data, run_word(i));
         end
         tick();
         strobe();
         n_checks++;
         if (dac_data !== run_word(i)) begin
            n_fail++; $display("FAIL run_ph1_word%0d: got %h want %h", i, dac_data, run_word(i));
         end
         tick();
      end
      n_checks++;
      if (fifo_count !== 5'd0 || underflow !== 1'b0) begin
         n_fail++; $display("FAIL run_end: got count %0d uf %b want 0 0", fifo_count, underflow);
      end
   endtask

   task automatic test_underflow();
      strobe();
      n_checks++;
      if (dac_data !== '0 || underflow !== 1'b1) begin
         n_fail++; $display("FAIL uf_set: got data %h uf %b want 0 1", dac_data, underflow);
      end
      n_checks++;
      if (tx_busy !== 1'b1) begin
         n_fail++; $display("FAIL uf_stay_run: got busy %b want 1", tx_busy);
      end
      tick();
      strobe();
      tick();
      write_word(64'h0ABC_0DEF_0123_0456);
      strobe();
      n_checks++;
      if (dac_data !== 64'h0ABC_0DEF_0123_0456 || underflow !== 1'b1) begin
         n_fail++; $display("FAIL uf_refill: got data %h uf %b want 0abc0def01230456 1", dac_data, underflow);
      end
      underflow_clr = 1'b1;
      tick();
      underflow_clr = 1'b0;
      n_checks++;
      if (underflow !== 1'b0) begin
         n_fail++; $display("FAIL uf_clear: got %b want 0", underflow);
      end
      strobe();
      tick();
   endtask

   task automatic test_atten();
      logic [DW-1:0] w;
      w = 64'hFFF8_000C_FFFF_7FFF;
      tx_atten = 3'd2;
      write_word(w);
      strobe();
      n_checks++;
      if (dac_data !== 64'hFFFE_0003_FFFF_1FFF) begin
         n_fail++; $display("FAIL atten2: got %h want fffe0003ffff1fff", dac_data);
      end
      tick();
      strobe();
      tick();
      tx_atten = 3'd4;
      write_word(w);
      strobe();
      n_checks++;
      if (dac_data !== 64'hFFFF_0000_FFFF_07FF) begin
         n_fail++; $display("FAIL atten4: got %h want ffff0000ffff07ff", dac_data);
      end
      tick();
      strobe();
      tick();
      tx_atten = 3'd6;
      write_word(w);
      strobe();
      n_checks++;
      if (dac_data !== w) begin
         n_fail++; $display("FAIL atten6: got %h want %h", dac_data, w);
      end
      tick();
      strobe();
      tick();
      tx_atten = 3'd0;
   endtask

   task automatic test_drain();
      for (int i = 0; i < 3; i++) write_word(run_word(i + 8));
      tx_en = 1'b0;
      tick();
      n_checks++;
      if (tx_busy !== 1'b1) begin
         n_fail++; $display("FAIL drain_busy: got %b want 1", tx_busy);
      end
      for (int i = 0; i < 3; i++) begin
         strobe();
         n_checks++;
         if (dac_data !== run_word(i + 8)) begin
            n_fail++; $display("FAIL drain_ph0_word%0d: got %h want %h", i, dac_data, run_word(i + 8));
         end
         tick();
         strobe();
         n_checks++;
         if (dac_data !== run_word(i + 8)) begin
            n_fail++; $display("FAIL drain_ph1_word%0d: got %h want %h", i, dac_data, run_word(i + 8));
         end
         tick();
      end
      strobe();
      n_checks++;
      if (dac_data !== '0) begin
         n_fail++; $display("FAIL drain_end_data: got %h want 0", dac_data);
      end
      n_checks++;
      if (tx_busy !== 1'b0) begin
         n_fail++; $display("FAIL drain_end_idle: got busy %b want 0", tx_busy);
      end
      n_checks++;
      if (underflow !== 1'b0) begin
         n_fail++; $display("FAIL drain_no_uf: got %b want 0", underflow);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < 4; i++) write_word(run_word(i));
      tx_en = 1'b1;
      tick();
      tick();
      strobe();
      n_checks++;
      if (dac_data !== run_word(0)) begin
         n_fail++; $display("FAIL midrst_first: got %h want %h", dac_data, run_word(0));
      end
      tick();
      write_word(run_word(5));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tx_en = 1'b0;
      n_checks++;
      if (fifo_count !== 5'd0 || dac_data !== '0) begin
         n_fail++; $display("FAIL midrst_clear: got count %0d data %h want 0 0", fifo_count, dac_data);
      end
      n_checks++;
      if (tx_busy !== 1'b0 || fulln !== 1'b1) begin
         n_fail++; $display("FAIL midrst_state: got busy %b fulln %b want 0 1", tx_busy, fulln);
      end
   endtask

   initial begin
      rst           = 1'b1;
      din           = '0;
      din_valid     = 1'b0;
      tx_en         = 1'b0;
      tx_atten      = 3'd0;
      dac_valid     = 1'b0;
      underflow_clr = 1'b0;
      tick();
      test_reset();
      test_fifo_full();
      test_run();
      test_underflow();
      test_atten();
      test_drain();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
